// File: rtl/usb_crc_serial_pkg.sv
// -----------------------------------------------------------------------------
// usb_crc_pkg
// Shared constants for the serial USB CRC engine:
//   - CRC5 (token) and CRC16 (data) generator, preload and good-packet residual
//   - FSM state encodings for usb_crc_serial
// Polynomials carry an implicit x^WIDTH term; bit WIDTH-1 is the MSB that is
// shifted out first.
// -----------------------------------------------------------------------------
package usb_crc_pkg;

    // CRC5: x^5 + x^2 + 1
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

    // CRC16: x^16 + x^15 + x^2 + 1
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // FSM encodings (plain constants so legacy tools can share them)
    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_DATA    = 3'd1;
    localparam logic [2:0]  ST_CRC_OUT = 3'd2;
    localparam logic [2:0]  ST_CHECK   = 3'd3;
    localparam logic [2:0]  ST_DONE    = 3'd4;

    // Bit-counter width able to hold WIDTH-1
    function automatic int crc_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/usb_crc_serial_if.sv
// -----------------------------------------------------------------------------
// usb_crc_serial_if
// Bit-serial link between the packet serialiser (master) and the CRC engine
// (slave). The engine output continues toward the bit-stuffer/NRZI stage.
//   start      master->slave  one-cycle packet start, latches mode
//   mode       master->slave  0 = generate (TX), 1 = check (RX)
//   halt_tx    master->slave  stuffing stall, freezes the engine
//   data_in    master->slave  serial payload bit
//   data_last  master->slave  marks the final bit of data_in
//   data_out   slave->master  serial bit toward the stuffer
//   crc_active slave->master  data_out carries a CRC bit
//   done       slave->master  end-of-packet pulse
//   error      slave->master  RX residual mismatch
//   int_data   slave->master  live LFSR contents
// -----------------------------------------------------------------------------
interface usb_crc_serial_if #(
    parameter int WIDTH = 16
);
    import usb_crc_pkg::*;

    logic             start;
    logic             mode;
    logic             halt_tx;
    logic             data_in;
    logic             data_last;
    logic             data_out;
    logic             crc_active;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] int_data;

    modport master (
        output start, mode, halt_tx, data_in, data_last,
        input  data_out, crc_active, done, error, int_data
    );

    modport slave (
        input  start, mode, halt_tx, data_in, data_last,
        output data_out, crc_active, done, error, int_data
    );

endinterface

// File: rtl/usb_crc_serial_lfsr_step.sv
// -----------------------------------------------------------------------------
// crc_lfsr_step
// Combinational single-bit step of an MSB-first Galois LFSR. Kept separate so
// parallel CRC blocks can chain several of these per clock.
//   crc_i  WIDTH  current remainder
//   bit_i  1      incoming serial bit
//   crc_o  WIDTH  remainder after absorbing bit_i
// -----------------------------------------------------------------------------
module crc_lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h8005
) (
    input  logic [WIDTH-1:0] crc_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] crc_o
);

    logic fb;

    assign fb    = bit_i ^ crc_i[WIDTH-1];
    assign crc_o = {crc_i[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_serial.sv
// -----------------------------------------------------------------------------
// usb_crc_serial
// Serial USB CRC engine, CRC5 or CRC16 selected by parameters (WIDTH 5 or 16).
//   TX (mode=0): payload bits pass through to data_out, then the complemented
//                remainder is appended MSB first with crc_active high.
//   RX (mode=1): payload plus received CRC run through the LFSR; the final
//                remainder is compared with RESIDUAL and error reports a miss.
// Ports:
//   clk_c  in  clock, all state on posedge
//   reset  in  synchronous active-low reset
//   bus    usb_crc_serial_if.slave (start/mode/halt_tx/data_in/data_last in;
//          data_out/crc_active/done/error/int_data out)
// Build option:
//   CRC_ERR_STICKY_EN  defined   -> error holds after a mismatch until
//                                   the next start or reset
//                      undefined -> error is a one-cycle pulse with done
// Timing: data_out, crc_active, done and error are all registered. done rises
// one cycle after the last CRC bit is on data_out (TX) or one cycle after the
// data_last bit is on data_out (RX).
// -----------------------------------------------------------------------------
module usb_crc_serial
    import usb_crc_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = CRC16_POLY,
    parameter logic [WIDTH-1:0] INIT     = CRC16_INIT,
    parameter logic [WIDTH-1:0] RESIDUAL = CRC16_RESIDUAL
) (
    input  logic             clk_c,
    input  logic             reset,
    usb_crc_serial_if.slave  bus
);

    localparam int CW = crc_cnt_w(WIDTH);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] crc_q,   crc_d;
    logic [WIDTH-1:0] crc_step;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    logic             dout_q,  dout_d;
    logic             act_q,   act_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    crc_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .crc_i (crc_q),
        .bit_i (bus.data_in),
        .crc_o (crc_step)
    );

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        act_d   = act_q;
        done_d  = 1'b0;
`ifdef CRC_ERR_STICKY_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif

        if (bus.start) begin
            // start wins in every state: an in-flight packet is dropped
            // silently (no done) and the engine re-arms.
            state_d = ST_DATA;
            crc_d   = INIT;
            cnt_d   = '0;
            mode_d  = bus.mode;
            dout_d  = 1'b0;
            act_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dout_d = 1'b0;
                    act_d  = 1'b0;
                end

                ST_DATA: begin
                    // A stalled cycle is invisible, including data_last;
                    // the source holds both until the stall drops.
                    if (!bus.halt_tx) begin
                        crc_d  = crc_step;
                        dout_d = bus.data_in;
                        if (bus.data_last) begin
                            state_d = mode_q ? ST_CHECK : ST_CRC_OUT;
                            cnt_d   = CW'(WIDTH - 1);
                        end
                    end
                end

                ST_CRC_OUT: begin
                    // Shift the remainder out MSB first, complemented. The
                    // counter only moves on emitted bits, so stalls never
                    // change how many CRC bits leave.
                    if (!bus.halt_tx) begin
                        dout_d = ~crc_q[WIDTH-1];
                        crc_d  = {crc_q[WIDTH-2:0], 1'b0};
                        act_d  = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end

                ST_CHECK: begin
                    err_d   = (crc_q != RESIDUAL);
                    done_d  = 1'b1;
                    dout_d  = 1'b0;
                    state_d = ST_IDLE;
                end

                ST_DONE: begin
                    done_d  = 1'b1;
                    act_d   = 1'b0;
                    dout_d  = 1'b0;
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_c) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            dout_q  <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            act_q   <= act_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.crc_active = act_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;
    assign bus.int_data   = crc_q;

endmodule

// File: doc/usb_crc_serial.md
Name: usb_crc_serial

Overview:
Parametrised serial USB CRC engine, generalising the fixed CRC-16 block to CRC5 (token) and CRC16 (data) through parameters.
- TX mode: passes payload bits through, then appends the complemented CRC, MSB first.
- RX mode: runs the LFSR over payload plus received CRC and checks the residual.
- Sits between the packet serialiser and the bit-stuffer/NRZI stage. Stuffing stalls arrive on halt_tx.

Parameters:
WIDTH, 16, CRC width; legal values 5 or 16.
POLY, 16'h8005, generator polynomial (implicit x^WIDTH term); use 5'h05 for CRC5.
INIT, 16'hFFFF, preload value; use 5'h1F for CRC5.
RESIDUAL, 16'h800D, good-packet remainder in RX mode; use 5'h0C for CRC5.

Ports:
clk_c  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; preloads INIT, latches mode, enters DATA
mode  in  1  0 = generate (TX), 1 = check (RX); sampled only on start
halt_tx  in  1  stall: no LFSR update, no counter advance, data_out holds
data_in  in  1  serial payload bit, MSB-first LFSR order
data_last  in  1  qualifies data_in as the final bit (TX: last payload bit; RX: last CRC bit)
data_out  out  1  TX: payload bit, then complemented CRC bits; RX: registered copy of data_in
crc_active  out  1  high while CRC bits drive data_out
done  out  1  one-cycle pulse at the end of a packet
error  out  1  RX residual mismatch
int_data  out  WIDTH  live LFSR contents

Behaviour:
- Reset (reset=0 at posedge): state IDLE, int_data=INIT, data_out=0, crc_active=0, done=0, error=0, bit counter=0.
- LFSR step, per non-stalled bit:
  - fb = data_in ^ int_data[WIDTH-1]
  - int_data <= {int_data[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- States:
  - IDLE: outputs idle. start -> DATA.
  - DATA: each cycle with halt_tx=0, step the LFSR and register data_out<=data_in. Cycles with halt_tx=1 have no effect.
    - data_last with mode=0 -> CRC_OUT, counter=WIDTH-1.
    - data_last with mode=1 -> CHECK.
  - CRC_OUT: data_out<=~int_data[WIDTH-1] and int_data shifts left with 0 fill, once per non-stalled cycle. crc_active=1. The counter decrements. At counter=0 with no stall -> DONE.
  - CHECK: single cycle. error<=(int_data!=RESIDUAL), done=1 -> IDLE.
  - DONE: done=1, crc_active=0 -> IDLE.
- Latency:
  - data_out lags data_in by 1 cycle.
  - The first CRC bit appears the cycle after the data_last bit is registered.
  - done fires 1 cycle after the last CRC bit (TX) or after the data_last bit (RX).
- halt_tx in CRC_OUT freezes both the counter and data_out, so exactly WIDTH CRC bits are emitted regardless of stalls.
- start in any non-IDLE state aborts the current packet and restarts DATA with INIT. done is not asserted for the aborted packet.
- data_last together with halt_tx=1 is ignored. The source holds both until halt_tx=0.
- error updates only in CHECK and clears on start. TX mode never sets error.
- reset mid-packet returns to the reset state on the next edge.

Optional Feature:
CRC_ERR_STICKY_EN
- Defined: error stays high after a mismatch until the next start or reset.
- Undefined: error is a one-cycle pulse coincident with done.

Decomposition:
- Package usb_crc_pkg holds:
  - CRC5/CRC16 constants: POLY, INIT, RESIDUAL.
  - State enum IDLE/DATA/CRC_OUT/CHECK/DONE.
- Sub-module crc_lfsr_step (combinational, parametrised WIDTH/POLY): inputs crc, bit; output next crc. Reused by future parallel CRC blocks.

Test Plan:
- CRC5 TX: 11 zero bits (addr 0, ep 0), data_last on bit 11 -> int_data=5'b10111 before CRC_OUT; data_out emits 0,1,0,0,0; done pulses once.
- CRC16 TX zero-length: start then data_last immediately with no payload is illegal, so instead check via RX. CRC16 RX: 16 zero bits with data_last on bit 16 -> int_data=16'h800D, error=0, done=1.
- Loopback: CRC16 TX of 8 bytes of 8'hA5, then the emitted 80-bit stream fed to RX -> error=0. Flip payload bit 3 -> error=1.
- halt_tx: TX CRC5 with halt_tx=1 for 3 cycles mid-CRC_OUT -> still exactly 5 CRC bits, same values as the unstalled run, data_out held during the stall.
- Abort: start reasserted in DATA after 6 bits, then a full 11-zero CRC5 packet -> output identical to the clean run; a single done.
- Reset: reset=0 during CRC_OUT -> next cycle int_data=INIT, crc_active=0, data_out=0, IDLE.
